mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, meaning number of requesters (2..4).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, meaning read-return tag FIFO depth (power of 2, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port port_ready  output  [NUM_PORTS]  per-port: request issues this cycle.
REQ-006 SHALL have port port_addr  input  [NUM_PORTS][32]  per-port address.
REQ-007 SHALL have port port_write_data  input  [NUM_PORTS][32]  per-port write data.
REQ-008 SHALL have port port_byte_enable  input  [NUM_PORTS][4]  per-port byte enables.
REQ-009 SHALL have port port_write_req  input  [NUM_PORTS]  per-port write request.
REQ-010 SHALL have port port_read_req  input  [NUM_PORTS]  per-port read request.
REQ-011 SHALL have port port_read_data  output  32  mem_read_data broadcast to all ports.
REQ-012 SHALL have port port_read_data_valid  output  [NUM_PORTS]  one-hot return strobe.
REQ-013 SHALL have ports mem_ready (in 1), mem_addr (out 32), mem_write_data (out 32), mem_byte_enable (out 4), mem_write_req (out 1), mem_read_req (out 1), mem_read_data (in 32), mem_read_data_valid (in 1): the shared memory bus.
REQ-014 SHALL have port err_unexpected_data  output  1  sticky: return data arrived with no read outstanding.

Function
REQ-015 SHALL treat port i as requesting when port_write_req[i] or port_read_req[i]; both high on one port is illegal (behaviour undefined, bench shall not drive it).
REQ-016 SHALL treat a port as eligible when requesting, except a read request is ineligible while the tag FIFO is full.
REQ-017 SHALL grant combinationally one eligible port via round-robin starting at priority pointer rr_ptr, searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
REQ-018 SHALL drive mem_addr/mem_write_data/mem_byte_enable from the granted port, and all zero when no grant.
REQ-019 SHALL drive mem_write_req/mem_read_req from the granted port's request only; at most one asserted.
REQ-020 SHALL issue a transaction in a cycle when a grant exists and mem_ready=1; port_ready[g]=1 for granted port g in exactly that cycle, all other bits 0.
REQ-021 SHALL, on issue from port g, update rr_ptr to (g+1) mod NUM_PORTS next cycle; rr_ptr unchanged when nothing issues.
REQ-022 SHALL push g into the tag FIFO on each read issue; writes never touch the FIFO.
REQ-023 SHALL, when mem_read_data_valid=1 and FIFO non-empty, assert port_read_data_valid[head] the same cycle (zero latency) and pop.
REQ-024 SHALL, when mem_read_data_valid=1 and FIFO empty, assert no port_read_data_valid bit and set err_unexpected_data next cycle.
REQ-025 SHALL compute fullness from the registered count only: a pop in the same cycle does not unblock a read while full.
REQ-026 SHALL handle simultaneous push and pop when not full or empty: count unchanged, order preserved.
REQ-027 SHALL pass port_read_data = mem_read_data unconditionally.
REQ-028 SHALL keep the tag FIFO count width clog2(MAX_OUTSTANDING)+1, with pointer wrap modulo MAX_OUTSTANDING.

Reset
REQ-029 SHALL, on reset, clear rr_ptr to 0, FIFO pointers and count to 0, and err_unexpected_data to 0.
REQ-030 SHALL drive port_ready=0, mem_read_req=0, mem_write_req=0 while reset is high, regardless of inputs.
REQ-031 SHALL discard outstanding tags on reset mid-operation; returns arriving after reset are treated as unexpected (REQ-024).

Structure
REQ-032 SHALL place ADDR_W=32, DATA_W=32, BE_W=4 constants and the mem-bus request struct typedef in shared package mem_arb_pkg.
REQ-033 SHALL implement the tag FIFO as sub-module read_tag_fifo (push, pop, full, empty, head).

Verification
REQ-034 Ports 0 and 1 read continuously, mem_ready=1 -> grants alternate 0,1,0,1; rr_ptr toggles every cycle.
REQ-035 Port 1 reads addr 0x100, then port 0 reads 0x200; memory returns 0xAAAA then 0xBBBB -> port_read_data_valid=2'b10 then 2'b01.
REQ-036 MAX_OUTSTANDING=4, 4 reads issued, none returned, port 0 read plus port 1 write pending -> port 1 write issues, port 0 read stalls until a return then issues next cycle.
REQ-037 mem_ready=0 for 3 cycles with port 0 write 0x10/0xDEADBEEF/BE 0xF pending -> port_ready=0 each cycle, issue on first cycle mem_ready=1, rr_ptr=1 after.
REQ-038 mem_read_data_valid=1 with nothing outstanding -> no port strobe, err_unexpected_data=1 next cycle, held until reset.
REQ-039 Reset asserted with 2 reads outstanding -> count 0, rr_ptr 0; subsequent return sets err_unexpected_data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and the memory-bus request type for the memory arbiter slice.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              write;
        logic              read;
    } mem_req_t;

    // Round-robin successor of a port index among n ports.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_read_tag_fifo.sv
// In-order FIFO of requester tags for reads awaiting return data.
module read_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [TAG_W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [TAG_W-1:0] slots [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = slots[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus among NUM_PORTS requesters,
// routing read returns back to the issuing port in order.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic [NUM_PORTS-1:0]              port_ready,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  port_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  port_write_data,
    input  logic [NUM_PORTS-1:0][BE_W-1:0]    port_byte_enable,
    input  logic [NUM_PORTS-1:0]              port_write_req,
    input  logic [NUM_PORTS-1:0]              port_read_req,
    output logic [DATA_W-1:0]                 port_read_data,
    output logic [NUM_PORTS-1:0]              port_read_data_valid,
    input  logic                              mem_ready,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_write_data,
    output logic [BE_W-1:0]                   mem_byte_enable,
    output logic                              mem_write_req,
    output logic                              mem_read_req,
    input  logic [DATA_W-1:0]                 mem_read_data,
    input  logic                              mem_read_data_valid,
    output logic                              err_unexpected_data
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic [NUM_PORTS-1:0] eligible;
    mem_req_t             req;
    logic                 issue;
    logic                 tag_full;
    logic                 tag_empty;
    logic [PTR_W-1:0]     tag_head;
    logic                 tag_push;
    logic                 tag_pop;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = port_write_req[i] | (port_read_req[i] & ~tag_full);
        end
    end

    always_comb begin
        int unsigned cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_PORTS;
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    // Reset is folded in as "no grant" so the bus stays idle and zero.
    always_comb begin
        req = '0;
        if (grant_valid && !reset) begin
            req.addr  = port_addr[grant_idx];
            req.wdata = port_write_data[grant_idx];
            req.be    = port_byte_enable[grant_idx];
            req.write = port_write_req[grant_idx];
            req.read  = port_read_req[grant_idx] & ~port_write_req[grant_idx];
        end
    end

    assign mem_addr        = req.addr;
    assign mem_write_data  = req.wdata;
    assign mem_byte_enable = req.be;
    assign mem_write_req   = req.write;
    assign mem_read_req    = req.read;

    assign issue    = grant_valid & mem_ready & ~reset;
    assign tag_push = issue & req.read;
    assign tag_pop  = mem_read_data_valid & ~tag_empty;

    always_comb begin
        port_ready = '0;
        if (issue) begin
            port_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        port_read_data_valid = '0;
        if (tag_pop) begin
            port_read_data_valid[tag_head] = 1'b1;
        end
    end

    assign port_read_data = mem_read_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= PTR_W'(rr_next(32'(grant_idx), NUM_PORTS));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_unexpected_data <= 1'b0;
        end else if (mem_read_data_valid && tag_empty) begin
            err_unexpected_data <= 1'b1;
        end
    end

    read_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TAG_W (PTR_W)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tag_push),
        .push_tag (grant_idx),
        .pop      (tag_pop),
        .full     (tag_full),
        .empty    (tag_empty),
        .head     (tag_head)
    );

endmodule
